// File: rtl/pair_stream_gen_pkg.sv
// Shared types and defaults for the pair stream generator.
// State encodings are exported as plain vectors for legacy FSM code.
package pair_stream_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_GAP_W = 4;

    typedef enum logic [3:0] {
        PRIME = 4'b0001,
        IDLE  = 4'b0010,
        HIGH  = 4'b0100,
        LOW   = 4'b1000
    } state_e;

    localparam logic [3:0] ST_PRIME = PRIME;
    localparam logic [3:0] ST_IDLE  = IDLE;
    localparam logic [3:0] ST_HIGH  = HIGH;
    localparam logic [3:0] ST_LOW   = LOW;

endpackage

// File: rtl/pair_stream_gen_if.sv
// Request handshake plus serial stream / prediction outputs of the generator.
interface pair_stream_gen_if #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [CNT_W-1:0] req_count;
    logic [GAP_W-1:0] req_gap;
    logic             dout;
    logic             exp_pulse;
    logic             busy;
    logic             done;

    modport master (
        output req_valid, req_count, req_gap,
        input  req_ready, dout, exp_pulse, busy, done
    );

    modport slave (
        input  req_valid, req_count, req_gap,
        output req_ready, dout, exp_pulse, busy, done
    );
endinterface

// File: rtl/pair_stream_gen_down_cnt.sv
// Loadable saturating down-counter; zero flags "is zero, or becomes zero on
// this decrement" so the FSM can leave a state in the same cycle.
module down_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0) || (dec && cnt == W'(1));

endmodule

// File: rtl/pair_stream_gen.sv
// Drives a pair-detecting FSM's din with 2N ones separated by G zeros and
// predicts, cycle-aligned, where that detector must pulse.
module pair_stream_gen
    import pair_stream_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic                clk,
    input  logic                rst_n,
    pair_stream_gen_if.slave    bus
);

    logic [3:0]       state;
    logic             phase;
    logic             done_q;
    logic [GAP_W-1:0] gap_q;
    logic             accept;
    logic             start;
    logic             ones_zero;
    logic             gap_zero;
    logic             gap_load;

    assign accept   = (state == ST_IDLE) && bus.req_valid;
    assign start    = accept && (bus.req_count != '0);
    assign gap_load = (state == ST_HIGH) && !ones_zero && (gap_q != '0);

    down_cnt #(.W(CNT_W + 1)) u_ones (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start),
        .load_val ({bus.req_count, 1'b0}),
        .dec      (state == ST_HIGH),
        .zero     (ones_zero)
    );

    down_cnt #(.W(GAP_W)) u_gap (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load),
        .load_val (gap_q),
        .dec      (state == ST_LOW),
        .zero     (gap_zero)
    );

    // Phase tracks whether the next 1 completes a pair for the detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_PRIME;
            phase  <= 1'b0;
            gap_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (accept && bus.req_count == '0) ||
                      (state == ST_HIGH && ones_zero);
            case (state)
                ST_PRIME: state <= ST_IDLE;
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_HIGH;
                        gap_q <= bus.req_gap;
                        phase <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    phase <= ~phase;
                    if (ones_zero)
                        state <= ST_IDLE;
                    else if (gap_q != '0)
                        state <= ST_LOW;
                end
                ST_LOW: begin
                    if (gap_zero)
                        state <= ST_HIGH;
                end
                default: state <= ST_PRIME;
            endcase
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.dout      = (state == ST_HIGH);
    assign bus.exp_pulse = (state == ST_HIGH) && phase;
    assign bus.busy      = (state == ST_HIGH) || (state == ST_LOW);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_pair_stream_gen.sv
// Directed bench for pair_stream_gen with a reference pair-detector model.
module tb_pair_stream_gen;

    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    pair_stream_gen_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

    pair_stream_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference detector: idle->s0 unconditionally, pulses on every second 1.
    typedef enum logic [1:0] {D_IDLE, D_S0, D_S1} det_e;
    det_e det;
    logic det_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            det <= D_IDLE;
        else begin
            case (det)
                D_IDLE:  det <= D_S0;
                D_S0:    if (bus.dout) det <= D_S1;
                D_S1:    if (bus.dout) det <= D_S0;
                default: det <= D_IDLE;
            endcase
        end
    end

    assign det_out = (det == D_S1) && bus.dout;

    typedef struct {
        logic [7:0]  n;
        logic [3:0]  g;
        int          len;
        logic [15:0] dout_exp;
        logic [15:0] pulse_exp;
    } vec_t;

    vec_t vecs[5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] n, input logic [3:0] g);
        bus.req_valid = 1'b1;
        bus.req_count = n;
        bus.req_gap   = g;
    endtask

    task automatic run_single_pair;
        tick;
        bus.req_valid = 1'b0;
        check_output("pair_c1_dout", 32'(bus.dout), 1);
        check_output("pair_c1_pulse", 32'(bus.exp_pulse), 0);
        tick;
        check_output("pair_c2_dout", 32'(bus.dout), 1);
        check_output("pair_c2_pulse", 32'(bus.exp_pulse), 1);
        check_output("pair_c2_det", 32'(det_out), 1);
        tick;
        check_output("pair_done", 32'(bus.done), 1);
        check_output("pair_done_ready", 32'(bus.req_ready), 1);
        check_output("pair_done_dout", 32'(bus.dout), 0);
    endtask

    initial begin
        int ones, zeros, pulses, det_mis, done_cyc;

        vecs[0] = '{n: 8'd1, g: 4'd3, len: 5, dout_exp: 16'h0011, pulse_exp: 16'h0010};
        vecs[1] = '{n: 8'd2, g: 4'd0, len: 4, dout_exp: 16'h000F, pulse_exp: 16'h000A};
        vecs[2] = '{n: 8'd1, g: 4'd0, len: 2, dout_exp: 16'h0003, pulse_exp: 16'h0002};
        vecs[3] = '{n: 8'd2, g: 4'd1, len: 7, dout_exp: 16'h0055, pulse_exp: 16'h0044};
        vecs[4] = '{n: 8'd3, g: 4'd0, len: 6, dout_exp: 16'h003F, pulse_exp: 16'h002A};

        bus.req_valid = 1'b0;
        bus.req_count = '0;
        bus.req_gap   = '0;

        // Reset values, then PRIME must ignore an early request.
        repeat (2) tick;
        check_output("rst_dout", 32'(bus.dout), 0);
        check_output("rst_pulse", 32'(bus.exp_pulse), 0);
        check_output("rst_ready", 32'(bus.req_ready), 0);
        check_output("rst_busy", 32'(bus.busy), 0);
        check_output("rst_done", 32'(bus.done), 0);
        rst_n = 1'b1;
        apply_stimulus(8'd1, 4'd0);
        #1;
        check_output("prime_ready", 32'(bus.req_ready), 0);
        check_output("prime_dout", 32'(bus.dout), 0);
        tick;
        check_output("idle_ready", 32'(bus.req_ready), 1);
        check_output("idle_dout", 32'(bus.dout), 0);
        run_single_pair;

        // Table vectors, each accepted in the previous request's done cycle.
        for (int v = 0; v < 5; v++) begin
            check_output("vec_ready", 32'(bus.req_ready), 1);
            apply_stimulus(vecs[v].n, vecs[v].g);
            tick;
            bus.req_valid = 1'b0;
            for (int c = 1; c <= vecs[v].len + 1; c++) begin
                check_output($sformatf("v%0d_c%0d_dout", v, c), 32'(bus.dout), 32'(vecs[v].dout_exp[c-1]));
                check_output($sformatf("v%0d_c%0d_pulse", v, c), 32'(bus.exp_pulse), 32'(vecs[v].pulse_exp[c-1]));
                check_output($sformatf("v%0d_c%0d_det", v, c), 32'(det_out), 32'(vecs[v].pulse_exp[c-1]));
                check_output($sformatf("v%0d_c%0d_done", v, c), 32'(bus.done), 32'(c == vecs[v].len + 1));
                check_output($sformatf("v%0d_c%0d_busy", v, c), 32'(bus.busy), 32'(c <= vecs[v].len));
                if (c <= vecs[v].len) tick;
            end
        end

        // N=0 completes with no stream; back-to-back request in that done cycle.
        apply_stimulus(8'd0, 4'd5);
        tick;
        check_output("n0_done", 32'(bus.done), 1);
        check_output("n0_ready", 32'(bus.req_ready), 1);
        check_output("n0_dout", 32'(bus.dout), 0);
        check_output("n0_busy", 32'(bus.busy), 0);
        apply_stimulus(8'd1, 4'd0);
        run_single_pair;

        // Reset during the LOW gap of an N=3, G=2 stream.
        apply_stimulus(8'd3, 4'd2);
        tick;
        bus.req_valid = 1'b0;
        check_output("abort_c1_dout", 32'(bus.dout), 1);
        tick;
        check_output("abort_c2_low", 32'(bus.dout), 0);
        check_output("abort_c2_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check_output("abort_dout", 32'(bus.dout), 0);
        check_output("abort_busy", 32'(bus.busy), 0);
        check_output("abort_ready", 32'(bus.req_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check_output("abort_no_done", 32'(bus.done), 0);
        end
        rst_n = 1'b1;
        #1;
        check_output("abort_prime_ready", 32'(bus.req_ready), 0);
        tick;
        check_output("abort_idle_ready", 32'(bus.req_ready), 1);
        check_output("abort_idle_done", 32'(bus.done), 0);
        apply_stimulus(8'd1, 4'd0);
        run_single_pair;

        // Largest request: N=255, G=15.
        apply_stimulus(8'd255, 4'd15);
        tick;
        bus.req_valid = 1'b0;
        ones = 0; zeros = 0; pulses = 0; det_mis = 0; done_cyc = 0;
        for (int cyc = 1; cyc <= 9000; cyc++) begin
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            if (bus.dout) ones++;
            if (!bus.dout && bus.busy) zeros++;
            if (bus.exp_pulse) pulses++;
            if (bus.exp_pulse !== det_out) det_mis++;
            tick;
        end
        check_output("big_done_cycle", 32'(done_cyc), 8146);
        check_output("big_ones", 32'(ones), 510);
        check_output("big_gap_zeros", 32'(zeros), 7635);
        check_output("big_pulses", 32'(pulses), 255);
        check_output("big_det_mismatches", 32'(det_mis), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
